// File: rtl/clkdiv_align_ctrl.sv
// Alignment controller for the downstream divide-by-DIVIDER stage: holds the divider
// in reset, slips its phase until the sync marker lands on TARGET, then monitors lock.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_HOLD   | divider held in reset for RST_HOLD cycles
// S_WAIT   | divider running, waiting for the first sync marker
// S_SLIP   | BIT_SLIP pulse cycle
// S_GAP    | settle for SLIP_GAP cycles after a slip
// S_VERIFY | all slips issued, next marker must be on-phase
// S_LOCKED | aligned, every marker checked against TARGET
module clkdiv_align_ctrl #(
  parameter int DIVIDER  = 4,
  parameter int TARGET   = 0,
  parameter int RST_HOLD = 16,
  parameter int SLIP_GAP = 8
) (
  input  logic                       CLK_IN,
  input  logic                       RESET,
  input  logic                       ALIGN_REQ,
  input  logic                       SYNC_MARK,
  output logic                       DIV_RST_N,
  output logic                       BIT_SLIP,
  output logic [$clog2(DIVIDER)-1:0] PHASE,
  output logic                       ALIGNED,
  output logic                       ERR,
  output logic [7:0]                 SLIP_CNT
);

  localparam int PW = $clog2(DIVIDER);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int GW = $clog2(SLIP_GAP + 1);

  localparam logic [PW-1:0] TGT       = PW'(TARGET);
  localparam logic [PW-1:0] DIV_M     = PW'(DIVIDER);
  localparam logic [PW-1:0] DIV_LAST  = PW'(DIVIDER - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(SLIP_GAP - 1);

  localparam logic [2:0] S_HOLD   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SLIP   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_VERIFY = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] rem;
  logic [PW-1:0] need;
  logic [PW:0]   diff;
  logic          start_slip;
  logic          latch_need;
  logic          lock;
  logic          lose;

  // NEED = (PHASE - TARGET) mod DIVIDER; a borrow means the raw difference went negative.
  always_comb begin
    diff = {1'b0, PHASE} - {1'b0, TGT};
    need = diff[PW-1:0];
    if (diff[PW]) begin
      need = diff[PW-1:0] + DIV_M;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_slip = 1'b0;
    latch_need = 1'b0;
    lock       = 1'b0;
    lose       = 1'b0;
    case (state)
      S_HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT, S_VERIFY: begin
        if (SYNC_MARK) begin
          if (need == '0) begin
            state_nxt = S_LOCKED;
            lock      = 1'b1;
          end else begin
            start_slip = 1'b1;
            latch_need = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (SYNC_MARK && (need != '0)) begin
          lose       = 1'b1;
          start_slip = 1'b1;
          latch_need = 1'b1;
        end
      end
      S_SLIP: begin
        state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          if (rem != '0) begin
            start_slip = 1'b1;
          end else begin
            state_nxt = S_VERIFY;
          end
        end
      end
      default: begin
        state_nxt = S_HOLD;
      end
    endcase
    if (start_slip) begin
      state_nxt = S_SLIP;
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state     <= S_HOLD;
      hold_cnt  <= HOLD_LOAD;
      gap_cnt   <= '0;
      rem       <= '0;
      DIV_RST_N <= 1'b0;
      BIT_SLIP  <= 1'b0;
      ALIGNED   <= 1'b0;
      ERR       <= 1'b0;
      SLIP_CNT  <= '0;
    end else if (ALIGN_REQ) begin
      state     <= S_HOLD;
      hold_cnt  <= HOLD_LOAD;
      gap_cnt   <= '0;
      rem       <= '0;
      DIV_RST_N <= 1'b0;
      BIT_SLIP  <= 1'b0;
      ALIGNED   <= 1'b0;
      ERR       <= 1'b0;
      SLIP_CNT  <= '0;
    end else begin
      state    <= state_nxt;
      BIT_SLIP <= start_slip;

      if (state == S_HOLD) begin
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
        end else begin
          DIV_RST_N <= 1'b1;
        end
      end else if (state_nxt == S_HOLD) begin
        hold_cnt  <= HOLD_LOAD;
        DIV_RST_N <= 1'b0;
      end

      if (state == S_SLIP) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == S_GAP) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end

      // rem counts the slips still owed after the pulse being issued now.
      if (latch_need) begin
        rem <= need - PW'(1);
      end else if (start_slip) begin
        rem <= rem - PW'(1);
      end

      if (start_slip && (SLIP_CNT != 8'hFF)) begin
        SLIP_CNT <= SLIP_CNT + 8'd1;
      end

      if (lock) begin
        ALIGNED <= 1'b1;
      end
      if (lose) begin
        ALIGNED <= 1'b0;
        ERR     <= 1'b1;
      end
    end
  end

  // Mirror of the divider phase; a slip stretches the divider by one input cycle.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      PHASE <= '0;
    end else if (ALIGN_REQ || !DIV_RST_N) begin
      PHASE <= '0;
    end else if (!BIT_SLIP) begin
      PHASE <= (PHASE == DIV_LAST) ? '0 : PHASE + PW'(1);
    end
  end

endmodule
